// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: ramps the PWM duty toward a target, then holds it for a set period count.
// Define PWM_SEQ_SAFE_SWITCH_EN to park duty at 0 until a period boundary on select changes.
module pwm_ramp_sequencer #(
  parameter int DUTY_W   = 7,
  parameter int DUTY_MAX = 100,
  parameter int STEP_W   = 4,
  parameter int HOLD_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              period_tick_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DUTY_W-1:0] cmd_duty_i,
  input  logic [STEP_W-1:0] cmd_step_i,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  input  logic              cmd_sel_i,
  input  logic              abort_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              sel_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, SWITCH, RAMP, HOLD} state_t;

  localparam logic [DUTY_W:0] MAX_W = (DUTY_W+1)'(DUTY_MAX);

  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
`ifdef PWM_SEQ_SAFE_SWITCH_EN
  logic              nsel_q, nsel_d;
`endif

  logic              accept;
  logic              up;
  logic [DUTY_W:0]   cmd_w, duty_w, tgt_w;
  logic [DUTY_W:0]   gap, mag, step_w, nxt;
  logic [DUTY_W-1:0] clamp;
  logic [DUTY_W-1:0] ramp_duty;

  assign cmd_ready_o = (state_q == IDLE) & ~abort_i;
  assign accept      = cmd_valid_i & cmd_ready_o;

  assign cmd_w = {1'b0, cmd_duty_i};
  assign clamp = (cmd_w > MAX_W) ? MAX_W[DUTY_W-1:0] : cmd_duty_i;

  // Ramp math one bit wide so neither direction can wrap.
  assign duty_w = {1'b0, duty_q};
  assign tgt_w  = {1'b0, tgt_q};
  assign step_w = (DUTY_W+1)'(step_q);
  assign up     = tgt_w > duty_w;
  assign gap    = up ? (tgt_w - duty_w) : (duty_w - tgt_w);
  assign mag    = ((step_q == '0) || (step_w > gap)) ? gap : step_w;
  assign nxt    = up ? (duty_w + mag) : (duty_w - mag);
  assign ramp_duty = nxt[DUTY_W] ? '1 : nxt[DUTY_W-1:0];

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
`ifdef PWM_SEQ_SAFE_SWITCH_EN
    nsel_d  = nsel_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d  = clamp;
          step_d = cmd_step_i;
          cnt_d  = cmd_hold_i;
`ifdef PWM_SEQ_SAFE_SWITCH_EN
          nsel_d = cmd_sel_i;
          if (cmd_sel_i != sel_q) begin
            duty_d  = '0;
            state_d = SWITCH;
          end else begin
            state_d = RAMP;
          end
`else
          sel_d   = cmd_sel_i;
          state_d = RAMP;
`endif
        end
      end
`ifdef PWM_SEQ_SAFE_SWITCH_EN
      SWITCH: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (period_tick_i) begin
          sel_d   = nsel_q;
          state_d = RAMP;
        end
      end
`endif
      RAMP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (duty_q == tgt_q) begin
          // A zero hold completes on arrival rather than spending a cycle in HOLD.
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else if (period_tick_i) begin
          duty_d = ramp_duty;
        end
      end
      HOLD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (period_tick_i) begin
          cnt_d = cnt_q - HOLD_W'(1);
          if (cnt_q == HOLD_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PWM_SEQ_SAFE_SWITCH_EN
      nsel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
`ifdef PWM_SEQ_SAFE_SWITCH_EN
      nsel_q  <= nsel_d;
`endif
    end
  end

  assign duty_o = duty_q;
  assign sel_o  = sel_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule
